// File: rtl/bp_fe_pkg.sv
// Front-end shared types: scan-sequencer state encoding, scan record and
// processor-configuration helpers.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_upper    = 2'd1,
        e_straddle = 2'd2
    } bp_fe_scan_seq_state_e;

    typedef enum int {
        e_bp_default_cfg,
        e_bp_no_compressed_cfg
    } bp_params_e;

    localparam int instr_width_gp = 32;

    typedef struct packed {
        logic full;
        logic clow;
        logic branch;
        logic jal;
        logic jalr;
        logic call;
        logic ret;
    } bp_fe_scan_s;

    function automatic int vaddr_width_f(input bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? 39 : 39;
    endfunction

    function automatic bit compressed_support_f(input bp_params_e cfg);
        return cfg != e_bp_no_compressed_cfg;
    endfunction

    // x1 and x5 are the RISC-V link registers for call/return hinting
    function automatic logic is_link_reg_f(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/bp_fe_scan.sv
// Control-flow pre-decoder for one instruction; compressed encodings occupy
// bits [15:0] with the upper half ignored.
module bp_fe_scan
    import bp_fe_pkg::*;
#(
    parameter bit compressed_support_p = 1'b1
) (
    input  logic [instr_width_gp-1:0] instr_i,
    output bp_fe_scan_s               scan_o
);

    logic       is_full;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] c_rs2;
    logic [4:0] c_key;
    logic [11:0] unused_imm;

    assign is_full    = (instr_i[1:0] == 2'b11);
    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign rs1        = instr_i[19:15];
    assign c_rs2      = instr_i[6:2];
    assign c_key      = {instr_i[15:13], instr_i[1:0]};
    assign unused_imm = instr_i[31:20];

    always_comb begin
        scan_o      = '0;
        scan_o.full = is_full;
        scan_o.clow = !is_full;
        if (is_full) begin
            case (opcode)
                7'b1100011: scan_o.branch = 1'b1;
                7'b1101111: begin
                    scan_o.jal  = 1'b1;
                    scan_o.call = is_link_reg_f(rd);
                end
                7'b1100111: begin
                    scan_o.jalr = 1'b1;
                    scan_o.call = is_link_reg_f(rd);
                    scan_o.ret  = !is_link_reg_f(rd) && is_link_reg_f(rs1);
                end
                default: ;
            endcase
        end else if (compressed_support_p) begin
            case (c_key)
                5'b101_01: scan_o.jal = 1'b1;
                5'b110_01,
                5'b111_01: scan_o.branch = 1'b1;
                // C.JR / C.JALR share a quadrant with C.MV/C.ADD; rs2==0 and rs1!=0 isolate them
                5'b100_10: begin
                    if (c_rs2 == 5'd0 && rd != 5'd0) begin
                        scan_o.jalr = 1'b1;
                        scan_o.call = instr_i[12];
                        scan_o.ret  = !instr_i[12] && is_link_reg_f(rd);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled flop with synchronous active-high reset to zero.
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            data_o <= '0;
        else if (en_i)
            data_o <= data_i;
    end

endmodule

// File: rtl/bp_fe_scan_sequencer.sv
// Splits 4-byte fetch parcels into single instructions with zero-cycle latency,
// holding the low half of an instruction that straddles two parcels.
module bp_fe_scan_sequencer
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int vaddr_width_p        = vaddr_width_f(bp_params_p),
    localparam bit compressed_support_p = compressed_support_f(bp_params_p),
    localparam int scan_width_lp        = $bits(bp_fe_scan_s)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      redirect_v_i,
    input  logic                      fetch_v_i,
    input  logic [vaddr_width_p-1:0]  fetch_pc_i,
    input  logic [instr_width_gp-1:0] fetch_data_i,
    output logic                      fetch_yumi_o,
    output logic                      instr_v_o,
    input  logic                      instr_ready_and_i,
    output logic [vaddr_width_p-1:0]  instr_pc_o,
    output logic [instr_width_gp-1:0] instr_o,
    output logic [scan_width_lp-1:0]  scan_o,
    output logic                      partial_v_o
);

    bp_fe_scan_seq_state_e state_r, state_n, eval_state;
    logic [1:0]               state_raw;
    logic [15:0]              held_half_r, held_half_n;
    logic [vaddr_width_p-1:0] held_pc_r, held_pc_n;
    logic                     held_en;
    logic                     upper_path;

    logic [15:0]              low_half, up_half;
    logic [vaddr_width_p-1:0] upper_pc, seq_pc;
    logic                     straddle_hit;
    bp_fe_scan_s              scan_lo;

    bsg_dff_reset_en #(.width_p(2)) state_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (1'b1),
        .data_i  (state_n),
        .data_o  (state_raw)
    );

    bsg_dff_reset_en #(.width_p(16)) held_half_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (held_en),
        .data_i  (held_half_n),
        .data_o  (held_half_r)
    );

    bsg_dff_reset_en #(.width_p(vaddr_width_p)) held_pc_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (held_en),
        .data_i  (held_pc_n),
        .data_o  (held_pc_r)
    );

    bp_fe_scan #(.compressed_support_p(compressed_support_p)) scan (
        .instr_i (instr_o),
        .scan_o  (scan_lo)
    );

    assign state_r      = bp_fe_scan_seq_state_e'(state_raw);
    assign scan_o       = scan_lo;
    assign partial_v_o  = (state_r == e_straddle);
    assign low_half     = fetch_data_i[15:0];
    assign up_half      = fetch_data_i[31:16];
    assign upper_pc     = {fetch_pc_i[vaddr_width_p-1:2], 2'b10};
    assign seq_pc       = held_pc_r + vaddr_width_p'(2);
    assign straddle_hit = fetch_v_i && (fetch_pc_i == seq_pc);
    // A non-sequential parcel abandons the held half and is treated as a fresh start
    assign eval_state   = (state_r == e_straddle && !straddle_hit) ? e_idle : state_r;

    always_comb begin
        instr_v_o    = 1'b0;
        instr_o      = fetch_data_i;
        instr_pc_o   = fetch_pc_i;
        fetch_yumi_o = 1'b0;
        state_n      = state_r;
        held_en      = 1'b0;
        held_half_n  = up_half;
        held_pc_n    = upper_pc;
        upper_path   = 1'b0;

        if (redirect_v_i) begin
            state_n     = e_idle;
            held_en     = 1'b1;
            held_half_n = '0;
            held_pc_n   = '0;
        end else if (!reset_i && fetch_v_i) begin
            state_n = eval_state;
            if (state_r == e_straddle && eval_state == e_idle) begin
                held_en     = 1'b1;
                held_half_n = '0;
                held_pc_n   = '0;
            end
            if (!compressed_support_p) begin
                instr_v_o    = 1'b1;
                fetch_yumi_o = instr_ready_and_i;
            end else begin
                case (eval_state)
                    e_idle: begin
                        if (fetch_pc_i[1]) begin
                            upper_path = 1'b1;
                        end else if (low_half[1:0] == 2'b11) begin
                            instr_v_o    = 1'b1;
                            fetch_yumi_o = instr_ready_and_i;
                        end else begin
                            instr_v_o = 1'b1;
                            instr_o   = {16'h0, low_half};
                            if (instr_ready_and_i)
                                state_n = e_upper;
                        end
                    end
                    e_upper: upper_path = 1'b1;
                    e_straddle: begin
                        instr_v_o  = 1'b1;
                        instr_o    = {low_half, held_half_r};
                        instr_pc_o = held_pc_r;
                        if (instr_ready_and_i)
                            state_n = e_upper;
                    end
                    default: state_n = e_idle;
                endcase

                if (upper_path) begin
                    if (up_half[1:0] != 2'b11) begin
                        instr_v_o  = 1'b1;
                        instr_o    = {16'h0, up_half};
                        instr_pc_o = upper_pc;
                        if (instr_ready_and_i) begin
                            fetch_yumi_o = 1'b1;
                            state_n      = e_idle;
                        end
                    end else begin
                        // Low half of a 32-bit instruction: park it and free the parcel
                        held_en      = 1'b1;
                        held_half_n  = up_half;
                        held_pc_n    = upper_pc;
                        fetch_yumi_o = 1'b1;
                        state_n      = e_straddle;
                    end
                end
            end
        end
    end

endmodule
